// File: rtl/graph_memory_responder_pkg.sv
// Shared defaults for the graph memory responder and its storage array.
package graph_memory_responder_pkg;

    localparam int DEFAULT_MADDR_WIDTH  = 16;
    localparam int DEFAULT_MDATA_WIDTH  = 32;
    localparam int DEFAULT_MEM_DEPTH    = 256;
    localparam int DEFAULT_READ_LATENCY = 2;
    localparam int LAT_CNT_W            = 4;
    localparam int STATS_W              = 32;

endpackage

// File: rtl/graph_mem_array.sv
// Single write port, asynchronous read storage for the adjacency matrix.
module graph_mem_array
    import graph_memory_responder_pkg::*;
#(
    parameter int DW    = DEFAULT_MDATA_WIDTH,
    parameter int DEPTH = DEFAULT_MEM_DEPTH,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/graph_memory_responder.sv
// Fixed-latency read responder over graph_mem_array with range checking.
// Define GRAPH_MEM_STATS_EN to add saturating read/error counters.
module graph_memory_responder
    import graph_memory_responder_pkg::*;
#(
    parameter int MADDR_WIDTH  = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH  = DEFAULT_MDATA_WIDTH,
    parameter int MEM_DEPTH    = DEFAULT_MEM_DEPTH,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] mem_addr,
    input  logic                   mem_read_enable,
    output logic [MDATA_WIDTH-1:0] mem_data,
    output logic                   mem_read_ready,
    output logic                   mem_addr_error,
    input  logic                   wr_enable,
    input  logic [MADDR_WIDTH-1:0] wr_addr,
    input  logic [MDATA_WIDTH-1:0] wr_data,
    output logic                   busy
`ifdef GRAPH_MEM_STATS_EN
    ,
    output logic [STATS_W-1:0]     read_count,
    output logic [STATS_W-1:0]     error_count
`endif
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND,
        TURN
    } state_e;

    state_e                 state_q;
    logic [LAT_CNT_W-1:0]   cnt_q;
    logic [MDATA_WIDTH-1:0] hold_q;
    logic                   hold_err_q;
    logic [MDATA_WIDTH-1:0] data_q;
    logic                   ready_q;
    logic                   err_q;
    logic                   busy_q;

    logic                   rd_oor;
    logic                   wr_oor;
    logic [MDATA_WIDTH-1:0] rd_word;
    logic [MDATA_WIDTH-1:0] rd_val;

    // Range checks see the whole address; the array only sees the low bits.
    assign rd_oor = 32'(mem_addr) >= 32'(MEM_DEPTH);
    assign wr_oor = 32'(wr_addr) >= 32'(MEM_DEPTH);
    assign rd_val = rd_oor ? '0 : rd_word;

    graph_mem_array #(
        .DW    (MDATA_WIDTH),
        .DEPTH (MEM_DEPTH),
        .IW    (IDX_W)
    ) u_array (
        .clk_i   (clock),
        .we_i    (wr_enable && !wr_oor),
        .waddr_i (wr_addr[IDX_W-1:0]),
        .wdata_i (wr_data),
        .raddr_i (mem_addr[IDX_W-1:0]),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_err_q <= 1'b0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_read_enable) begin
                        hold_q     <= rd_val;
                        hold_err_q <= rd_oor;
                        cnt_q      <= LAT_CNT_W'(READ_LATENCY - 1);
                        busy_q     <= 1'b1;
                        if (READ_LATENCY == 1) begin
                            state_q <= RESPOND;
                            ready_q <= 1'b1;
                            data_q  <= rd_val;
                            err_q   <= rd_oor;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - LAT_CNT_W'(1);
                    if (cnt_q == LAT_CNT_W'(1)) begin
                        state_q <= RESPOND;
                        ready_q <= 1'b1;
                        data_q  <= hold_q;
                        err_q   <= hold_err_q;
                    end
                end
                RESPOND: begin
                    state_q <= TURN;
                end
                TURN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_data       = data_q;
    assign mem_read_ready = ready_q;
    assign mem_addr_error = err_q;
    assign busy           = busy_q;

`ifdef GRAPH_MEM_STATS_EN
    logic [STATS_W-1:0] rd_cnt_q;
    logic [STATS_W-1:0] rd_cnt_d;
    logic [STATS_W-1:0] er_cnt_q;
    logic [STATS_W-1:0] er_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        er_cnt_d = er_cnt_q;
        if (ready_q && !(&rd_cnt_q)) begin
            rd_cnt_d = rd_cnt_q + STATS_W'(1);
        end
        if (ready_q && err_q && !(&er_cnt_q)) begin
            er_cnt_d = er_cnt_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign read_count  = rd_cnt_q;
    assign error_count = er_cnt_q;
`endif

endmodule
